// File: rtl/intersection_phase_arbiter.sv
// rtl/intersection_phase_arbiter.sv - actuated right-of-way scheduler for a two-way intersection
// Arbitrates NS, EW and pedestrian demand through GREEN -> YELLOW -> ALL_RED sequencing.
module intersection_phase_arbiter #(
  parameter int CW           = 6,
  parameter int STARTUP_TIME = 15,
  parameter int MIN_GREEN    = 10,
  parameter int MAX_GREEN    = 60,
  parameter int YELLOW_TIME  = 4,
  parameter int ALLRED_TIME  = 3,
  parameter int WALK_TIME    = 8
) (
  input  logic clk,
  input  logic resetn,
  input  logic tick,
  input  logic ns_req,
  input  logic ew_req,
  input  logic ped_req,
  output logic ns_green,
  output logic ns_yellow,
  output logic ns_red,
  output logic ew_green,
  output logic ew_yellow,
  output logic ew_red,
  output logic walk,
  output logic ped_pending
);

  typedef enum logic [2:0] {
    ST_STARTUP   = 3'd0,
    ST_ALL_RED   = 3'd1,
    ST_NS_GREEN  = 3'd2,
    ST_NS_YELLOW = 3'd3,
    ST_EW_GREEN  = 3'd4,
    ST_EW_YELLOW = 3'd5,
    ST_PED_WALK  = 3'd6
  } state_t;

  // Timer values at which the D-th tick of a state lands.
  localparam logic [CW-1:0] T_STARTUP = CW'(STARTUP_TIME - 1);
  localparam logic [CW-1:0] T_MIN     = CW'(MIN_GREEN - 1);
  localparam logic [CW-1:0] T_MAX     = CW'(MAX_GREEN - 1);
  localparam logic [CW-1:0] T_YELLOW  = CW'(YELLOW_TIME - 1);
  localparam logic [CW-1:0] T_ALLRED  = CW'(ALLRED_TIME - 1);
  localparam logic [CW-1:0] T_WALK    = CW'(WALK_TIME - 1);

  state_t        state;
  state_t        state_nxt;
  state_t        decision;
  logic [CW-1:0] timer;
  logic          last_dir_ew;
  logic          ped_served;
  logic          opp_req;
  logic          same_req;
  logic          ns_exit;
  logic          ew_exit;
  logic          state_change;
  logic          enter_walk;
  logic          enter_ns;
  logic          enter_ew;

  // Right-of-way choice at the end of every clearance interval.
  always_comb begin
    decision = ST_ALL_RED;
    opp_req  = last_dir_ew ? ns_req : ew_req;
    same_req = last_dir_ew ? ew_req : ns_req;
    if (ped_pending && !ped_served) begin
      decision = ST_PED_WALK;
    end else if (opp_req) begin
      decision = last_dir_ew ? ST_NS_GREEN : ST_EW_GREEN;
    end else if (same_req) begin
      decision = last_dir_ew ? ST_EW_GREEN : ST_NS_GREEN;
    end else begin
      decision = last_dir_ew ? ST_NS_GREEN : ST_EW_GREEN;
    end
  end

  always_comb begin
    ns_exit = 1'b0;
    ew_exit = 1'b0;
    if (tick && (ew_req || ped_pending)) begin
      ns_exit = ((timer >= T_MIN) && !ns_req) || (timer >= T_MAX);
    end
    if (tick && (ns_req || ped_pending)) begin
      ew_exit = ((timer >= T_MIN) && !ew_req) || (timer >= T_MAX);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_STARTUP: begin
        if (tick && (timer == T_STARTUP)) state_nxt = decision;
      end
      ST_ALL_RED: begin
        if (tick && (timer == T_ALLRED)) state_nxt = decision;
      end
      ST_NS_GREEN: begin
        if (ns_exit) state_nxt = ST_NS_YELLOW;
      end
      ST_NS_YELLOW: begin
        if (tick && (timer == T_YELLOW)) state_nxt = ST_ALL_RED;
      end
      ST_EW_GREEN: begin
        if (ew_exit) state_nxt = ST_EW_YELLOW;
      end
      ST_EW_YELLOW: begin
        if (tick && (timer == T_YELLOW)) state_nxt = ST_ALL_RED;
      end
      ST_PED_WALK: begin
        if (tick && (timer == T_WALK)) state_nxt = ST_ALL_RED;
      end
      default: state_nxt = ST_ALL_RED;
    endcase
  end

  always_comb begin
    state_change = (state_nxt != state);
    enter_walk   = state_change && (state_nxt == ST_PED_WALK);
    enter_ns     = state_change && (state_nxt == ST_NS_GREEN);
    enter_ew     = state_change && (state_nxt == ST_EW_GREEN);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= ST_STARTUP;
      timer <= '0;
    end else begin
      state <= state_nxt;
      if (state_change) begin
        timer <= '0;
      end else if (tick && (timer != '1)) begin
        timer <= timer + 1'b1;
      end
    end
  end

  // ped_served blocks a second walk until a vehicle green has been granted.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      last_dir_ew <= 1'b1;
      ped_pending <= 1'b0;
      ped_served  <= 1'b0;
    end else begin
      if (enter_ns) begin
        last_dir_ew <= 1'b0;
      end else if (enter_ew) begin
        last_dir_ew <= 1'b1;
      end
      if (enter_walk) begin
        ped_pending <= 1'b0;
      end else if (ped_req) begin
        ped_pending <= 1'b1;
      end
      if (enter_walk) begin
        ped_served <= 1'b1;
      end else if (enter_ns || enter_ew) begin
        ped_served <= 1'b0;
      end
    end
  end

  // Lamps are registered from the next state so they track state exactly.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ns_green  <= 1'b0;
      ns_yellow <= 1'b0;
      ns_red    <= 1'b1;
      ew_green  <= 1'b0;
      ew_yellow <= 1'b0;
      ew_red    <= 1'b1;
      walk      <= 1'b0;
    end else begin
      ns_green  <= (state_nxt == ST_NS_GREEN);
      ns_yellow <= (state_nxt == ST_NS_YELLOW);
      ns_red    <= !((state_nxt == ST_NS_GREEN) || (state_nxt == ST_NS_YELLOW));
      ew_green  <= (state_nxt == ST_EW_GREEN);
      ew_yellow <= (state_nxt == ST_EW_YELLOW);
      ew_red    <= !((state_nxt == ST_EW_GREEN) || (state_nxt == ST_EW_YELLOW));
      walk      <= (state_nxt == ST_PED_WALK);
    end
  end

endmodule

// File: tb/tb_intersection_phase_arbiter.sv
// tb/tb_intersection_phase_arbiter.sv - directed table-driven bench for intersection_phase_arbiter
module tb_intersection_phase_arbiter;

  localparam logic [2:0] G = 3'b100;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] R = 3'b001;

  localparam logic [1:0] K_STEP = 2'd0;
  localparam logic [1:0] K_RST  = 2'd1;
  localparam logic [1:0] K_ARST = 2'd2;

  typedef struct {
    logic [1:0] kind;
    logic       tick;
    logic       ns;
    logic       ew;
    logic       ped;
    logic [2:0] nsl;
    logic [2:0] ewl;
    logic       walk;
    logic       pp;
  } row_t;

  logic clk = 1'b0;
  logic resetn = 1'b1;
  logic tick = 1'b0;
  logic ns_req = 1'b0;
  logic ew_req = 1'b0;
  logic ped_req = 1'b0;
  logic ns_green, ns_yellow, ns_red;
  logic ew_green, ew_yellow, ew_red;
  logic walk, ped_pending;

  int n_cmp = 0;
  int n_bad = 0;
  row_t rows[$];

  intersection_phase_arbiter #(
    .CW(6), .STARTUP_TIME(5), .MIN_GREEN(3), .MAX_GREEN(6),
    .YELLOW_TIME(2), .ALLRED_TIME(1), .WALK_TIME(4)
  ) dut (
    .clk(clk), .resetn(resetn), .tick(tick),
    .ns_req(ns_req), .ew_req(ew_req), .ped_req(ped_req),
    .ns_green(ns_green), .ns_yellow(ns_yellow), .ns_red(ns_red),
    .ew_green(ew_green), .ew_yellow(ew_yellow), .ew_red(ew_red),
    .walk(walk), .ped_pending(ped_pending)
  );

  always #5 clk = ~clk;

  task automatic add(input int n, input logic t, input logic ns, input logic ew, input logic ped,
                     input logic [2:0] nsl, input logic [2:0] ewl, input logic w, input logic pp);
    row_t r;
    r.kind = K_STEP; r.tick = t; r.ns = ns; r.ew = ew; r.ped = ped;
    r.nsl = nsl; r.ewl = ewl; r.walk = w; r.pp = pp;
    for (int i = 0; i < n; i++) rows.push_back(r);
  endtask

  task automatic add_reset(input logic [1:0] kind, input logic ns, input logic ew);
    row_t r;
    r.kind = kind; r.tick = 1'b1; r.ns = ns; r.ew = ew; r.ped = 1'b0;
    r.nsl = R; r.ewl = R; r.walk = 1'b0; r.pp = 1'b0;
    rows.push_back(r);
  endtask

  // Three idle cycles then one tick cycle: lamps before and after the tick edge.
  task automatic add4(input logic ns, input logic ew, input logic [2:0] nsb, input logic [2:0] ewb,
                      input logic [2:0] nsa, input logic [2:0] ewa);
    add(3, 1'b0, ns, ew, 1'b0, nsb, ewb, 1'b0, 1'b0);
    add(1, 1'b1, ns, ew, 1'b0, nsa, ewa, 1'b0, 1'b0);
  endtask

  task automatic check_row(input int idx, input row_t r);
    logic [7:0] act;
    logic [7:0] exp;
    act = {ns_green, ns_yellow, ns_red, ew_green, ew_yellow, ew_red, walk, ped_pending};
    exp = {r.nsl, r.ewl, r.walk, r.pp};
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL row%0d lamps: got %b expected %b", idx, act, exp);
    end
    n_cmp++;
    if (!($countones({ns_green, ns_yellow, ns_red}) == 1 &&
          $countones({ew_green, ew_yellow, ew_red}) == 1 && (ns_red || ew_red))) begin
      n_bad++;
      $display("FAIL row%0d safety: ns=%b%b%b ew=%b%b%b", idx,
               ns_green, ns_yellow, ns_red, ew_green, ew_yellow, ew_red);
    end
  endtask

  task automatic apply(input int idx, input row_t r);
    tick = r.tick; ns_req = r.ns; ew_req = r.ew; ped_req = r.ped;
    case (r.kind)
      K_RST: begin
        resetn = 1'b0;
        @(posedge clk); #1;
        check_row(idx, r);
        resetn = 1'b1;
      end
      K_ARST: begin
        #3 resetn = 1'b0;
        #1 check_row(idx, r);
        #2 resetn = 1'b1;
      end
      default: begin
        @(posedge clk); #1;
        check_row(idx, r);
      end
    endcase
  endtask

  initial begin
    // Idle start-up then an indefinitely resting NS green.
    add_reset(K_RST, 0, 0);
    add(4, 1, 0, 0, 0, R, R, 0, 0);
    add(101, 1, 0, 0, 0, G, R, 0, 0);

    // EW demand at green cycle 0: 3 green, 2 yellow, 1 all-red, EW green.
    add_reset(K_RST, 0, 0);
    add(4, 1, 0, 0, 0, R, R, 0, 0);
    add(1, 1, 0, 0, 0, G, R, 0, 0);
    add(2, 1, 0, 1, 0, G, R, 0, 0);
    add(2, 1, 0, 1, 0, Y, R, 0, 0);
    add(1, 1, 0, 1, 0, R, R, 0, 0);
    add(6, 1, 0, 1, 0, R, G, 0, 0);

    // Both directions held: MAX_GREEN greens, alternating.
    add_reset(K_RST, 1, 1);
    add(4, 1, 1, 1, 0, R, R, 0, 0);
    add(6, 1, 1, 1, 0, G, R, 0, 0);
    add(2, 1, 1, 1, 0, Y, R, 0, 0);
    add(1, 1, 1, 1, 0, R, R, 0, 0);
    add(6, 1, 1, 1, 0, R, G, 0, 0);
    add(2, 1, 1, 1, 0, R, Y, 0, 0);
    add(1, 1, 1, 1, 0, R, R, 0, 0);
    add(6, 1, 1, 1, 0, G, R, 0, 0);

    // Pedestrian walk, re-request during walk served after one vehicle green.
    add_reset(K_RST, 0, 0);
    add(4, 1, 0, 0, 0, R, R, 0, 0);
    add(1, 1, 0, 0, 0, G, R, 0, 0);
    add(1, 1, 0, 0, 1, G, R, 0, 1);
    add(1, 1, 0, 0, 0, G, R, 0, 1);
    add(2, 1, 0, 0, 0, Y, R, 0, 1);
    add(1, 1, 0, 0, 0, R, R, 0, 1);
    add(1, 1, 0, 0, 0, R, R, 1, 0);
    add(1, 1, 0, 0, 1, R, R, 1, 1);
    add(2, 1, 0, 0, 0, R, R, 1, 1);
    add(1, 1, 0, 0, 0, R, R, 0, 1);
    add(3, 1, 0, 0, 0, R, G, 0, 1);
    add(2, 1, 0, 0, 0, R, Y, 0, 1);
    add(1, 1, 0, 0, 0, R, R, 0, 1);
    add(1, 1, 0, 0, 0, R, R, 1, 0);

    // Tick every 4th cycle: everything scales by 4, nothing moves off-tick.
    add_reset(K_RST, 0, 0);
    for (int i = 0; i < 4; i++) add4(0, 0, R, R, R, R);
    add4(0, 0, R, R, G, R);
    add4(0, 1, G, R, G, R);
    add4(0, 1, G, R, G, R);
    add4(0, 1, G, R, Y, R);
    add4(0, 1, Y, R, Y, R);
    add4(0, 1, Y, R, R, R);
    add4(0, 1, R, R, R, G);

    // Asynchronous reset in EW yellow with a pending pedestrian, then restart.
    add_reset(K_RST, 0, 1);
    add(4, 1, 0, 1, 0, R, R, 0, 0);
    add(1, 1, 0, 1, 0, R, G, 0, 0);
    add(1, 1, 0, 0, 1, R, G, 0, 1);
    add(1, 1, 0, 0, 0, R, G, 0, 1);
    add(1, 1, 0, 0, 0, R, Y, 0, 1);
    add_reset(K_ARST, 0, 0);
    add(4, 1, 0, 0, 0, R, R, 0, 0);
    add(1, 1, 0, 0, 0, G, R, 0, 0);

    for (int i = 0; i < rows.size(); i++) apply(i, rows[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/intersection_phase_arbiter.md
Name: intersection_phase_arbiter

Overview:
- Actuated phase scheduler for a two-way intersection.
- Arbitrates the single shared resource, right-of-way, between three requesters: NS vehicle sensor, EW vehicle sensor and a pedestrian push-button.
- Sequences GREEN -> YELLOW -> ALL_RED between phases and drives the six lamp outputs plus a walk signal.
- Sits between the sensor/button synchronisers and the lamp drivers; all timing is counted in ticks of an external timebase strobe.

Parameters:
- CW, 6, width of the phase timer; all time parameters must be < 2^CW.
- STARTUP_TIME, 15, all-red ticks after reset.
- MIN_GREEN, 10, minimum green ticks, >= 1.
- MAX_GREEN, 60, maximum green ticks under conflicting demand, >= MIN_GREEN.
- YELLOW_TIME, 4, yellow ticks, >= 1.
- ALLRED_TIME, 3, all-red clearance ticks, >= 1.
- WALK_TIME, 8, pedestrian walk ticks, >= 1.

Ports:
- clk  input  1  system clock
- resetn  input  1  reset, asynchronous, active-low
- tick  input  1  one-cycle timebase strobe; timers advance only when high
- ns_req  input  1  NS vehicle present (level, already synchronised)
- ew_req  input  1  EW vehicle present (level, already synchronised)
- ped_req  input  1  pedestrian button (pulse or level)
- ns_green, ns_yellow, ns_red  output  1 each  NS lamps
- ew_green, ew_yellow, ew_red  output  1 each  EW lamps
- walk  output  1  pedestrian walk lamp
- ped_pending  output  1  latched, unserved pedestrian request

Behaviour:
- Reset: the clock and reset are clk and resetn; resetn is asynchronous, active-low. While resetn is low:
  - state = STARTUP, last_dir = EW, ped_pending = 0, ped_served = 0, timer = 0.
  - Outputs: ns_red = ew_red = 1, all other lamp outputs and walk = 0.
  - Reset asserted mid-phase forces this immediately, independent of clk.
- States: STARTUP, ALL_RED, NS_GREEN, NS_YELLOW, EW_GREEN, EW_YELLOW, PED_WALK. Any illegal encoding goes to ALL_RED on the next clk.
- Timer:
  - Cleared to 0 on every state change.
  - Increments on tick cycles, saturating at 2^CW-1.
  - State transitions happen only on clk edges where tick = 1.
  - A fixed-duration state of D ticks exits on its D-th tick, i.e. when tick = 1 and timer == D-1.
- Lamp outputs:
  - Registered; a pure decode of state with no combinational path from the inputs.
  - NS_GREEN/NS_YELLOW: NS lamp set accordingly, ew_red = 1.
  - EW_GREEN/EW_YELLOW: EW lamp set accordingly, ns_red = 1.
  - STARTUP, ALL_RED, PED_WALK: both directions red.
  - walk = 1 only in PED_WALK.
- Exactly one NS lamp and exactly one EW lamp are lit every cycle.
- Pedestrian latch:
  - ped_pending is set by ped_req = 1.
  - It is cleared on the edge that enters PED_WALK; a ped_req in that same cycle is absorbed.
  - A ped_req during PED_WALK sets ped_pending again.
- Decision at exit of STARTUP (STARTUP_TIME) or ALL_RED (ALLRED_TIME), first match wins:
  1. ped_pending & !ped_served -> PED_WALK.
  2. Request of the direction opposite last_dir -> that green.
  3. Request of last_dir -> last_dir green.
  4. No request -> green opposite last_dir.
- Entering a green: sets last_dir to that direction and clears ped_served.
- Entering PED_WALK: sets ped_served = 1. This prevents back-to-back walks, so vehicles cannot be starved.
- Green exit, NS shown; EW is symmetric:
  - Conflict = ew_req | ped_pending.
  - On a tick, exit to NS_YELLOW when conflict & ((timer >= MIN_GREEN-1 & !ns_req) | timer >= MAX_GREEN-1).
  - With no conflict, green rests indefinitely; the timer saturates.
- Fixed transitions:
  - YELLOW -> ALL_RED after YELLOW_TIME.
  - PED_WALK -> ALL_RED after WALK_TIME.
- Green always passes through YELLOW then ALL_RED; there is no direct green-to-green or green-to-walk transition.
- Simultaneous ns_req and ew_req at a decision point: rule 2 alternates direction (round-robin).

Test Plan:
All scenarios use CW=6, STARTUP=5, MIN=3, MAX=6, YELLOW=2, ALLRED=1, WALK=4, tick=1 every cycle.

- Reset, no requests -> all red for 5 cycles, then NS_GREEN; rests; ew_red stays 1 for 100 cycles.
- In NS_GREEN with ns_req=0, raise ew_req at green cycle 0 -> exit after 3 green cycles, 2 yellow, 1 all-red, then EW_GREEN.
- ns_req=1 and ew_req=1 held -> NS green lasts exactly 6 cycles (MAX); phases alternate NS/EW; no green ever overlaps a non-red opposing lamp.
- ped_req pulse during NS_GREEN -> ped_pending=1; after yellow and all-red, walk=1 for 4 cycles; ped_pending clears on entry. A second ped_req during the walk is served only after one vehicle green.
- Assert resetn=0 mid-EW_YELLOW, asynchronous to clk -> outputs go to all red, walk=0 and ped_pending=0 immediately; 5-cycle STARTUP after release.
- tick high only every 4th cycle -> all durations scale by 4 and no transition occurs on a non-tick cycle.
